// File: rtl/led_shift_pkg.sv
// Shared definitions for the LED pattern stepper: mode codes,
// bounce direction encoding and the per-mode seed pattern.
package led_shift_pkg;

    localparam logic [1:0] MODE_ROTL   = 2'b00;
    localparam logic [1:0] MODE_ROTR   = 2'b01;
    localparam logic [1:0] MODE_BOUNCE = 2'b10;
    localparam logic [1:0] MODE_COUNT  = 2'b11;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_e;

    // Widest LED bank the seed function can describe.
    localparam int SEED_W = 32;

    function automatic logic [SEED_W-1:0] seed_of(
        input logic [1:0]  m,
        input int unsigned n
    );
        logic [SEED_W-1:0] s;
        s = '0;
        case (m)
            MODE_ROTL:   s = SEED_W'(1);
            MODE_ROTR:   s = SEED_W'(1) << (n - 1);
            MODE_BOUNCE: s = SEED_W'(1);
            default:     s = '0;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/led_tick_gen.sv
// Step-cadence prescaler: counts enabled clk cycles, pulses tick
// every TICK_DIV of them. Ports: clk, rst_n (sync), en, tick.
module led_tick_gen #(
    parameter int TICK_DIV = 25000000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    output logic tick
);

    localparam int CW = $clog2(TICK_DIV);
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] count;

    assign tick = en && (count == LAST);

    // Pausing freezes the count so the cadence resumes mid-period.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count <= '0;
        end else if (tick) begin
            count <= '0;
        end else if (en) begin
            count <= count + CW'(1);
        end
    end

endmodule

// File: rtl/led_shift_counter.sv
// LED pattern stepper: rotate-left/right, bounce or binary count.
// Ports: clk, rst_n, en, mode, step_req -> led, step_pulse, wrap.
module led_shift_counter
    import led_shift_pkg::*;
#(
    parameter int TICK_DIV = 25000000,
    parameter int N_LED    = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic             step_req,
    output logic [N_LED-1:0] led,
    output logic             step_pulse,
    output logic             wrap
);

    logic tick;
    logic step_q;
    logic sedge;
    logic do_step;

    logic [1:0]       mode_q;
    dir_e             dir;
    logic [N_LED-1:0] led_n;
    dir_e             dir_n;
    logic             wrap_n;

    led_tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en),
        .tick  (tick)
    );

    // Button edges only step while paused; a coincident tick
    // and edge still collapse into a single step.
    assign sedge   = step_req & ~step_q;
    assign do_step = tick | (~en & sedge);

    always_comb begin
        led_n  = led;
        dir_n  = dir;
        wrap_n = 1'b0;
        if (mode != mode_q) begin
            // A mode switch spends its step on the seed.
            led_n = N_LED'(seed_of(mode, N_LED));
            if (mode == MODE_BOUNCE) begin
                dir_n = DIR_UP;
            end
        end else begin
            unique case (1'b1)
                (mode_q == MODE_ROTL): begin
                    led_n  = {led[N_LED-2:0], led[N_LED-1]};
                    wrap_n = led[N_LED-1];
                end
                (mode_q == MODE_ROTR): begin
                    led_n  = {led[0], led[N_LED-1:1]};
                    wrap_n = led[0];
                end
                (mode_q == MODE_BOUNCE): begin
                    if (dir == DIR_UP) begin
                        if (led[N_LED-1]) begin
                            led_n  = N_LED'(1) << (N_LED - 2);
                            dir_n  = DIR_DOWN;
                            wrap_n = 1'b1;
                        end else begin
                            led_n = led << 1;
                        end
                    end else begin
                        if (led[0]) begin
                            led_n  = N_LED'(2);
                            dir_n  = DIR_UP;
                            wrap_n = 1'b1;
                        end else begin
                            led_n = led >> 1;
                        end
                    end
                end
                (mode_q == MODE_COUNT): begin
                    led_n  = led + N_LED'(1);
                    wrap_n = &led;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            led        <= N_LED'(1);
            dir        <= DIR_UP;
            mode_q     <= MODE_ROTL;
            step_q     <= 1'b0;
            step_pulse <= 1'b0;
            wrap       <= 1'b0;
        end else begin
            step_q     <= step_req;
            step_pulse <= do_step;
            wrap       <= do_step & wrap_n & (mode == mode_q);
            if (do_step) begin
                led    <= led_n;
                dir    <= dir_n;
                mode_q <= mode;
            end
        end
    end

endmodule

// File: tb/tb_led_shift_counter.sv
// Directed bench for led_shift_counter with TICK_DIV=4, N_LED=8.
// Inputs change 1 time unit after each rising edge; outputs sampled there.
module tb_led_shift_counter;

    localparam int TD = 4;
    localparam int N  = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         en = 1'b0;
    logic [1:0]   mode = 2'b00;
    logic         step_req = 1'b0;
    logic [N-1:0] led;
    logic         step_pulse;
    logic         wrap;

    int n_checks = 0;
    int n_fail   = 0;

    led_shift_counter #(
        .TICK_DIV (TD),
        .N_LED    (N)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .mode       (mode),
        .step_req   (step_req),
        .led        (led),
        .step_pulse (step_pulse),
        .wrap       (wrap)
    );

    always #5 clk = ~clk;

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        en    = 1'b1;
        mode  = 2'b00;
        cyc(3);
        n_checks++;
        if (led !== 8'h01 || step_pulse !== 1'b0 || wrap !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state: led=%h pulse=%b wrap=%b, want 01 0 0",
                     led, step_pulse, wrap);
        end
        rst_n = 1'b1;
        cyc(3);
        n_checks++;
        if (led !== 8'h01 || step_pulse !== 1'b0) begin
            n_fail++;
            $display("FAIL first_step_early: led=%h pulse=%b, want 01 0", led, step_pulse);
        end
        cyc(1);
        n_checks++;
        if (led !== 8'h02 || step_pulse !== 1'b1 || wrap !== 1'b0) begin
            n_fail++;
            $display("FAIL rotl_edge4: led=%h pulse=%b wrap=%b, want 02 1 0",
                     led, step_pulse, wrap);
        end
        cyc(4);
        n_checks++;
        if (led !== 8'h04) begin
            n_fail++;
            $display("FAIL rotl_edge8: led=%h, want 04", led);
        end
        cyc(24);
        n_checks++;
        if (led !== 8'h01 || step_pulse !== 1'b1 || wrap !== 1'b1) begin
            n_fail++;
            $display("FAIL rotl_wrap: led=%h pulse=%b wrap=%b, want 01 1 1",
                     led, step_pulse, wrap);
        end
        cyc(1);
        n_checks++;
        if (step_pulse !== 1'b0 || wrap !== 1'b0) begin
            n_fail++;
            $display("FAIL rotl_pulse_width: pulse=%b wrap=%b, want 0 0", step_pulse, wrap);
        end
    endtask

    task automatic test_bounce;
        logic [7:0] exp_led [16];
        logic       exp_wrap [16];
        exp_led = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80,
                    8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h02};
        exp_wrap = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1};
        // Sitting 1 cycle past the wrap step, so next tick is 3 edges away.
        mode = 2'b10;
        cyc(3);
        for (int i = 0; i < 16; i++) begin
            n_checks++;
            if (led !== exp_led[i] || wrap !== exp_wrap[i] || step_pulse !== 1'b1) begin
                n_fail++;
                $display("FAIL bounce_step%0d: led=%h wrap=%b pulse=%b, want %h %b 1",
                         i, led, wrap, step_pulse, exp_led[i], exp_wrap[i]);
            end
            if (i < 15) cyc(4);
        end
    endtask

    task automatic test_count;
        mode = 2'b11;
        cyc(4);
        n_checks++;
        if (led !== 8'h00 || wrap !== 1'b0) begin
            n_fail++;
            $display("FAIL count_seed: led=%h wrap=%b, want 00 0", led, wrap);
        end
        for (int i = 1; i < 256; i++) begin
            cyc(4);
            n_checks++;
            if (led !== 8'(i) || wrap !== 1'b0) begin
                n_fail++;
                $display("FAIL count_step%0d: led=%h wrap=%b, want %h 0", i, led, wrap, 8'(i));
            end
        end
        cyc(4);
        n_checks++;
        if (led !== 8'h00 || wrap !== 1'b1) begin
            n_fail++;
            $display("FAIL count_wrap: led=%h wrap=%b, want 00 1", led, wrap);
        end
    endtask

    task automatic test_pause_step;
        int pulses;
        int changes;
        logic [7:0] prev;
        // Prescaler count is 0 here; two edges bring it to 2.
        cyc(2);
        en       = 1'b0;
        step_req = 1'b1;
        pulses   = 0;
        changes  = 0;
        prev     = led;
        for (int i = 0; i < 40; i++) begin
            cyc(1);
            if (i == 9) step_req = 1'b0;
            if (step_pulse === 1'b1) pulses++;
            if (led !== prev) changes++;
            prev = led;
        end
        n_checks++;
        if (pulses !== 1 || changes !== 1 || led !== 8'h01) begin
            n_fail++;
            $display("FAIL pause_single_step: pulses=%0d changes=%0d led=%h, want 1 1 01",
                     pulses, changes, led);
        end
        en = 1'b1;
        cyc(1);
        n_checks++;
        if (step_pulse !== 1'b0 || led !== 8'h01) begin
            n_fail++;
            $display("FAIL resume_early: pulse=%b led=%h, want 0 01", step_pulse, led);
        end
        cyc(1);
        n_checks++;
        if (step_pulse !== 1'b1 || led !== 8'h02) begin
            n_fail++;
            $display("FAIL resume_count_kept: pulse=%b led=%h, want 1 02", step_pulse, led);
        end
        step_req = 1'b1;
        pulses   = 0;
        for (int i = 0; i < 3; i++) begin
            cyc(1);
            if (step_pulse === 1'b1) pulses++;
        end
        n_checks++;
        if (pulses !== 0 || led !== 8'h02) begin
            n_fail++;
            $display("FAIL edge_ignored_running: pulses=%0d led=%h, want 0 02", pulses, led);
        end
        cyc(1);
        n_checks++;
        if (step_pulse !== 1'b1 || led !== 8'h03) begin
            n_fail++;
            $display("FAIL tick_after_edge: pulse=%b led=%h, want 1 03", step_pulse, led);
        end
        step_req = 1'b0;
    endtask

    task automatic test_reset_mid;
        int pulses;
        mode = 2'b10;
        cyc(44);
        n_checks++;
        if (led !== 8'h10) begin
            n_fail++;
            $display("FAIL mid_setup: led=%h, want 10", led);
        end
        rst_n = 1'b0;
        cyc(1);
        n_checks++;
        if (led !== 8'h01 || step_pulse !== 1'b0 || wrap !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_reset_state: led=%h pulse=%b wrap=%b, want 01 0 0",
                     led, step_pulse, wrap);
        end
        rst_n  = 1'b1;
        pulses = 0;
        for (int i = 0; i < 3; i++) begin
            cyc(1);
            if (step_pulse === 1'b1) pulses++;
        end
        n_checks++;
        if (pulses !== 0) begin
            n_fail++;
            $display("FAIL mid_no_early_step: pulses=%0d, want 0", pulses);
        end
        cyc(1);
        n_checks++;
        if (step_pulse !== 1'b1 || led !== 8'h01 || wrap !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_seed_load: pulse=%b led=%h wrap=%b, want 1 01 0",
                     step_pulse, led, wrap);
        end
        cyc(4);
        n_checks++;
        if (led !== 8'h02 || wrap !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_dir_up: led=%h wrap=%b, want 02 0", led, wrap);
        end
    endtask

    task automatic test_simultaneous;
        cyc(3);
        step_req = 1'b1;
        cyc(1);
        n_checks++;
        if (step_pulse !== 1'b1 || led !== 8'h04) begin
            n_fail++;
            $display("FAIL sim_tick_edge: pulse=%b led=%h, want 1 04", step_pulse, led);
        end
        cyc(1);
        n_checks++;
        if (step_pulse !== 1'b0 || led !== 8'h04) begin
            n_fail++;
            $display("FAIL sim_single_step: pulse=%b led=%h, want 0 04", step_pulse, led);
        end
        step_req = 1'b0;
        cyc(2);
        mode = 2'b01;
        cyc(1);
        n_checks++;
        if (step_pulse !== 1'b1 || led !== 8'h80 || wrap !== 1'b0) begin
            n_fail++;
            $display("FAIL sim_mode_seed: pulse=%b led=%h wrap=%b, want 1 80 0",
                     step_pulse, led, wrap);
        end
        for (int i = 1; i < 8; i++) begin
            cyc(4);
            n_checks++;
            if (led !== (8'h80 >> i) || wrap !== 1'b0) begin
                n_fail++;
                $display("FAIL rotr_step%0d: led=%h wrap=%b, want %h 0",
                         i, led, wrap, 8'h80 >> i);
            end
        end
        cyc(4);
        n_checks++;
        if (led !== 8'h80 || wrap !== 1'b1) begin
            n_fail++;
            $display("FAIL rotr_wrap: led=%h wrap=%b, want 80 1", led, wrap);
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: time limit reached, want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_bounce();
        test_count();
        test_pause_step();
        test_reset_mid();
        test_simultaneous();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
